// File: rtl/display_scan_ctrl.sv
// Multiplexes eight hex digits onto one 7-segment bus, inserting a blank gap between digits.
// Define LEADING_ZERO_BLANK_EN to darken the leading zero digits 2..7.
module display_scan_ctrl #(
    parameter int DWELL_CYCLES   = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int ACTIVE_LOW_OUT = 1
) (
    input  logic        clk_1,
    input  logic        rst_n,
    input  logic        display_en_i,
    input  logic [31:0] digits_i,
    input  logic [7:0]  dp_mask_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o,
    output logic [2:0]  digit_idx_o,
    output logic        frame_o
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic             POL        = (ACTIVE_LOW_OUT != 0);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [2:0]       idx_r, idx_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             capture_s;
    logic             frame_s;
    logic [3:0]       held_digit_r;
    logic             held_dp_r;
    logic             held_dark_r;
    logic [3:0]       digit_sel_s;
    logic             dp_sel_s;
    logic             dark_sel_s;
    logic             lit_s;
    logic [7:0]       an_act_s;
    logic [6:0]       seg_act_s;
    logic             dp_act_s;
    logic [7:0]       an_r;
    logic [6:0]       seg_r;
    logic             dp_r;
    logic             frame_r;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'h3F;
            4'h1:    hex_to_seg = 7'h06;
            4'h2:    hex_to_seg = 7'h5B;
            4'h3:    hex_to_seg = 7'h4F;
            4'h4:    hex_to_seg = 7'h66;
            4'h5:    hex_to_seg = 7'h6D;
            4'h6:    hex_to_seg = 7'h7D;
            4'h7:    hex_to_seg = 7'h07;
            4'h8:    hex_to_seg = 7'h7F;
            4'h9:    hex_to_seg = 7'h6F;
            4'hA:    hex_to_seg = 7'h77;
            4'hB:    hex_to_seg = 7'h7C;
            4'hC:    hex_to_seg = 7'h39;
            4'hD:    hex_to_seg = 7'h5E;
            4'hE:    hex_to_seg = 7'h79;
            4'hF:    hex_to_seg = 7'h71;
            default: hex_to_seg = 7'h00;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // A digit at k>=2 is dark when it and every more significant digit are zero.
    function automatic logic leading_zero(input logic [31:0] d, input logic [2:0] k);
        logic z;
        z = (k >= 3'd2);
        for (int j = 0; j < 8; j++) begin
            z = z && !((j >= int'(k)) && (d[4*j +: 4] != 4'h0));
        end
        return z;
    endfunction
`endif

    // Next-state: count out each BLANK/SHOW phase and advance the digit index.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if ((BLANK_CYCLES == 0) || (cnt_r == BLANK_LAST)) begin
                    state_s   = ST_SHOW;
                    cnt_s     = '0;
                    capture_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SHOW: begin
                if (cnt_r == DWELL_LAST) begin
                    idx_s = idx_r + 3'd1;
                    cnt_s = '0;
                    if (BLANK_CYCLES == 0) begin
                        state_s   = ST_SHOW;
                        capture_s = 1'b1;
                    end else begin
                        state_s = ST_BLANK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_BLANK;
                idx_s   = 3'd0;
                cnt_s   = '0;
            end
        endcase
    end

    // Frame pulse marks the final SHOW cycle of digit 7, registered alongside the state.
    assign frame_s     = (state_s == ST_SHOW) && (cnt_s == DWELL_LAST) && (idx_s == 3'd7);
    assign digit_sel_s = digits_i[{idx_s, 2'b00} +: 4];
    assign dp_sel_s    = dp_mask_i[idx_s];
`ifdef LEADING_ZERO_BLANK_EN
    assign dark_sel_s  = leading_zero(digits_i, idx_s);
`else
    assign dark_sel_s  = 1'b0;
`endif

    // Lit-digit drive in active-high form, derived from the registered state.
    assign lit_s     = (state_r == ST_SHOW) && display_en_i && !held_dark_r;
    assign an_act_s  = lit_s ? (8'd1 << idx_r) : 8'd0;
    assign seg_act_s = lit_s ? hex_to_seg(held_digit_r) : 7'd0;
    assign dp_act_s  = lit_s && held_dp_r;

    // State, counter, index, digit holding register and frame pulse.
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            state_r      <= ST_BLANK;
            idx_r        <= 3'd0;
            cnt_r        <= '0;
            held_digit_r <= 4'h0;
            held_dp_r    <= 1'b0;
            held_dark_r  <= 1'b0;
            frame_r      <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            cnt_r   <= cnt_s;
            frame_r <= frame_s;
            if (capture_s) begin
                held_digit_r <= digit_sel_s;
                held_dp_r    <= dp_sel_s;
                held_dark_r  <= dark_sel_s;
            end else begin
                held_digit_r <= held_digit_r;
                held_dp_r    <= held_dp_r;
                held_dark_r  <= held_dark_r;
            end
        end
    end

    // Pin drivers, polarity applied here; reset leaves everything dark.
    always_ff @(posedge clk_1) begin
        if (!rst_n) begin
            an_r  <= {8{POL}};
            seg_r <= {7{POL}};
            dp_r  <= POL;
        end else begin
            an_r  <= an_act_s ^ {8{POL}};
            seg_r <= seg_act_s ^ {7{POL}};
            dp_r  <= dp_act_s ^ POL;
        end
    end

    assign an_o        = an_r;
    assign seg_o       = seg_r;
    assign dp_o        = dp_r;
    assign digit_idx_o = idx_r;
    assign frame_o     = frame_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with DWELL=4, BLANK=1, active-low outputs.
// Frame is 40 cycles; after n enabled edges the visible digit is ((n-1)/5)%8, dark when (n-1)%5==0.
module tb_display_scan_ctrl;

    logic        clk_1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        display_en_i = 1'b0;
    logic [31:0] digits_i = 32'h0;
    logic [7:0]  dp_mask_i = 8'h0;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;
    logic [2:0]  digit_idx_o;
    logic        frame_o;

    int checks = 0;
    int errors = 0;
    int n = 0;

    // Active-low segment patterns for 0..F, written out by hand.
    logic [6:0] seg_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    display_scan_ctrl #(.DWELL_CYCLES(4), .BLANK_CYCLES(1), .ACTIVE_LOW_OUT(1)) dut (
        .clk_1(clk_1), .rst_n(rst_n), .display_en_i(display_en_i), .digits_i(digits_i),
        .dp_mask_i(dp_mask_i), .an_o(an_o), .seg_o(seg_o), .dp_o(dp_o),
        .digit_idx_o(digit_idx_o), .frame_o(frame_o)
    );

    always #5 clk_1 = ~clk_1;

    task automatic step();
        @(posedge clk_1);
        #1;
        n = n + 1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
    endtask

    function automatic int vis_digit(input int k);
        return ((k - 1) / 5) % 8;
    endfunction

    function automatic logic vis_lit(input int k);
        return ((k - 1) % 5) != 0;
    endfunction

    function automatic logic [7:0] an_for(input int d);
        logic [7:0] t;
        t = 8'd1 << d;
        return ~t;
    endfunction

    task automatic test_reset();
        digits_i = 32'h8765_4321; display_en_i = 1'b1; dp_mask_i = 8'h00;
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (an_o !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected ff", an_o); end
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg_o); end
        checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp_o); end
        checks++; if (frame_o !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame_o); end
        checks++; if (digit_idx_o !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", digit_idx_o); end
        rst_n = 1'b1; n = 0;
        step();
        checks++; if (an_o !== 8'hFF) begin errors++; $display("FAIL release_an: got %h expected ff", an_o); end
        step();
        checks++; if (an_o !== 8'hFE) begin errors++; $display("FAIL first_lit_an: got %h expected fe", an_o); end
        checks++; if (seg_o !== 7'h79) begin errors++; $display("FAIL first_lit_seg: got %h expected 79", seg_o); end
    endtask

    task automatic test_scan();
        int d; logic lit; int frames;
        logic [7:0] e_an; logic [6:0] e_seg; logic [2:0] e_idx; logic e_fr;
        digits_i = 32'h8765_4321; display_en_i = 1'b1; dp_mask_i = 8'h00;
        do_reset();
        frames = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            d = vis_digit(n); lit = vis_lit(n);
            e_an  = lit ? an_for(d) : 8'hFF;
            e_seg = lit ? seg_lut[d + 1] : 7'h7F;
            e_idx = 3'((n / 5) % 8);
            e_fr  = ((n % 40) == 39);
            if (frame_o === 1'b1) frames++;
            checks++; if (an_o !== e_an) begin errors++; $display("FAIL scan_an n=%0d: got %h expected %h", n, an_o, e_an); end
            checks++; if (seg_o !== e_seg) begin errors++; $display("FAIL scan_seg n=%0d: got %h expected %h", n, seg_o, e_seg); end
            checks++; if (dp_o !== 1'b1) begin errors++; $display("FAIL scan_dp n=%0d: got %b expected 1", n, dp_o); end
            checks++; if (digit_idx_o !== e_idx) begin errors++; $display("FAIL scan_idx n=%0d: got %0d expected %0d", n, digit_idx_o, e_idx); end
            checks++; if (frame_o !== e_fr) begin errors++; $display("FAIL scan_frame n=%0d: got %b expected %b", n, frame_o, e_fr); end
        end
        checks++; if (frames != 2) begin errors++; $display("FAIL scan_frame_count: got %0d expected 2", frames); end
    endtask

    task automatic test_no_tear();
        logic [6:0] e_seg;
        digits_i = 32'h8765_4321; display_en_i = 1'b1; dp_mask_i = 8'h00;
        do_reset();
        for (int i = 0; i < 45; i++) begin
            step();
            if (n == 3) digits_i[3:0] = 4'h9;
            if (vis_lit(n) && vis_digit(n) == 0) begin
                e_seg = (n <= 40) ? 7'h79 : 7'h10;
                checks++; if (seg_o !== e_seg) begin errors++; $display("FAIL tear_seg n=%0d: got %h expected %h", n, seg_o, e_seg); end
            end
        end
    endtask

    task automatic test_disable();
        logic e_fr; logic [7:0] e_an;
        digits_i = 32'h8765_4321; display_en_i = 1'b0; dp_mask_i = 8'h00;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            step();
            e_fr = ((n % 40) == 39);
            checks++; if (an_o !== 8'hFF) begin errors++; $display("FAIL dis_an n=%0d: got %h expected ff", n, an_o); end
            checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL dis_seg n=%0d: got %h expected 7f", n, seg_o); end
            checks++; if (frame_o !== e_fr) begin errors++; $display("FAIL dis_frame n=%0d: got %b expected %b", n, frame_o, e_fr); end
        end
        for (int i = 0; i < 6; i++) begin
            step();
            e_an = (vis_lit(n) && n >= 84) ? an_for(vis_digit(n)) : 8'hFF;
            checks++; if (an_o !== e_an) begin errors++; $display("FAIL en_rise_an n=%0d: got %h expected %h", n, an_o, e_an); end
            if (n == 83) display_en_i = 1'b1;
        end
    endtask

    task automatic test_hex_dp();
        logic [31:0] v0, v1, v; int d; logic lit; logic [3:0] nib;
        logic [7:0] e_an; logic [6:0] e_seg; logic e_dp;
        v0 = 32'h1234_0E56; v1 = 32'hFEDC_BA98;
        digits_i = v0; display_en_i = 1'b1; dp_mask_i = 8'h04;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            step();
            d = vis_digit(n); lit = vis_lit(n);
            v = (n <= 40) ? v0 : v1;
            nib = v[4*d +: 4];
            e_an  = lit ? an_for(d) : 8'hFF;
            e_seg = lit ? seg_lut[nib] : 7'h7F;
            e_dp  = !(lit && d == 2);
            checks++; if (an_o !== e_an) begin errors++; $display("FAIL hex_an n=%0d: got %h expected %h", n, an_o, e_an); end
            checks++; if (seg_o !== e_seg) begin errors++; $display("FAIL hex_seg n=%0d: got %h expected %h", n, seg_o, e_seg); end
            checks++; if (dp_o !== e_dp) begin errors++; $display("FAIL hex_dp n=%0d: got %b expected %b", n, dp_o, e_dp); end
            if (n == 40) digits_i = v1;
        end
        dp_mask_i = 8'h00;
    endtask

    task automatic test_reset_mid();
        digits_i = 32'h8765_4321; display_en_i = 1'b1; dp_mask_i = 8'h00;
        do_reset();
        repeat (27) step();
        checks++; if (digit_idx_o !== 3'd5) begin errors++; $display("FAIL mid_pre_idx: got %0d expected 5", digit_idx_o); end
        checks++; if (an_o !== 8'hDF) begin errors++; $display("FAIL mid_pre_an: got %h expected df", an_o); end
        rst_n = 1'b0;
        step();
        checks++; if (digit_idx_o !== 3'd0) begin errors++; $display("FAIL mid_rst_idx: got %0d expected 0", digit_idx_o); end
        checks++; if (an_o !== 8'hFF) begin errors++; $display("FAIL mid_rst_an: got %h expected ff", an_o); end
        checks++; if (seg_o !== 7'h7F) begin errors++; $display("FAIL mid_rst_seg: got %h expected 7f", seg_o); end
        rst_n = 1'b1; n = 0;
        step(); step();
        checks++; if (an_o !== 8'hFE) begin errors++; $display("FAIL mid_restart_an: got %h expected fe", an_o); end
        checks++; if (seg_o !== 7'h79) begin errors++; $display("FAIL mid_restart_seg: got %h expected 79", seg_o); end
        checks++; if (digit_idx_o !== 3'd0) begin errors++; $display("FAIL mid_restart_idx: got %0d expected 0", digit_idx_o); end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_lzb();
        int d; logic lit; logic dark; logic [7:0] e_an;
        digits_i = 32'h0000_1234; display_en_i = 1'b1; dp_mask_i = 8'h00;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            step();
            d = vis_digit(n); lit = vis_lit(n);
            dark = (n <= 40) ? (d >= 4) : (d >= 2);
            e_an = (lit && !dark) ? an_for(d) : 8'hFF;
            checks++; if (an_o !== e_an) begin errors++; $display("FAIL lzb_an n=%0d: got %h expected %h", n, an_o, e_an); end
            if (n > 40 && lit && d < 2) begin
                checks++; if (seg_o !== 7'h40) begin errors++; $display("FAIL lzb_seg n=%0d: got %h expected 40", n, seg_o); end
            end
            if (n == 40) digits_i = 32'h0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_no_tear();
        test_disable();
        test_hex_dp();
        test_reset_mid();
`ifdef LEADING_ZERO_BLANK_EN
        test_lzb();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
